// File: rtl/seg_display_driver.sv
// Four-digit 7-segment driver: binary input -> BCD via sequential double-dabble,
// committed to the display registers only on a scan strobe so a scan never tears.
module seg_display_driver #(
  parameter int DIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIN_W-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [3:0]       anode,
  input  logic             en,
  input  logic             blank_lz,
  input  logic [3:0]       dp_mask,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [3:0]       an_out,
  output logic             ovf
);

  localparam int SR_W  = DIN_W + 16;
  localparam int CNT_W = $clog2(DIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t            state, state_nxt;
  logic [SR_W-1:0]   shift_reg;
  logic [SR_W-1:0]   adjusted;
  logic [CNT_W-1:0]  iter;
  logic              pend_ovf;
  logic [3:0]        d3, d2, d1, d0;
  logic              accept;
  logic              over_range;
  logic              conv_done;

  assign accept     = din_valid && din_ready;
  assign over_range = (din > DIN_W'(MAX_VAL));
  assign conv_done  = (iter == CNT_W'(DIN_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = over_range ? COMMIT : CONVERT;
      CONVERT: if (conv_done) state_nxt = COMMIT;
      COMMIT:  if (en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    din_ready = rst_n && (state == IDLE);
  end

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    adjusted = shift_reg;
    for (int k = 0; k < 4; k++) begin
      if (shift_reg[DIN_W + 4*k +: 4] >= 4'd5)
        adjusted[DIN_W + 4*k +: 4] = shift_reg[DIN_W + 4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg <= '0;
      iter      <= '0;
      pend_ovf  <= 1'b0;
      d3        <= 4'd0;
      d2        <= 4'd0;
      d1        <= 4'd0;
      d0        <= 4'd0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pend_ovf  <= over_range;
            shift_reg <= over_range ? '0 : {16'b0, din};
            iter      <= '0;
          end
        end
        CONVERT: begin
          shift_reg <= {adjusted[SR_W-2:0], 1'b0};
          iter      <= iter + 1'b1;
        end
        COMMIT: begin
          if (en) begin
            d3  <= shift_reg[SR_W-1 -: 4];
            d2  <= shift_reg[SR_W-5 -: 4];
            d1  <= shift_reg[SR_W-9 -: 4];
            d0  <= shift_reg[SR_W-13 -: 4];
            ovf <= pend_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'h7F;
    endcase
  endfunction

  logic [1:0] sel;
  logic       sel_valid;
  logic [3:0] digit;
  logic       blanked;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic [3:0] an_nxt;

  always_comb begin
    sel       = 2'd0;
    sel_valid = 1'b1;
    case (anode)
      4'b0001: sel = 2'd0;
      4'b0010: sel = 2'd1;
      4'b0100: sel = 2'd2;
      4'b1000: sel = 2'd3;
      default: sel_valid = 1'b0;
    endcase
  end

  // Leading-zero blanking never touches digit 0 and is suppressed on overflow.
  always_comb begin
    digit   = d0;
    blanked = 1'b0;
    case (sel)
      2'd3: begin
        digit   = d3;
        blanked = (d3 == 4'd0);
      end
      2'd2: begin
        digit   = d2;
        blanked = (d3 == 4'd0) && (d2 == 4'd0);
      end
      2'd1: begin
        digit   = d1;
        blanked = (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0);
      end
      default: begin
        digit   = d0;
        blanked = 1'b0;
      end
    endcase
    blanked = blanked && blank_lz && !ovf;
  end

  always_comb begin
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    an_nxt  = 4'hF;
    if (sel_valid) begin
      an_nxt = ~anode;
      dp_nxt = ~dp_mask[sel];
      if (ovf)          seg_nxt = 7'b0111111;
      else if (blanked) seg_nxt = 7'h7F;
      else              seg_nxt = decode(digit);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg    <= 7'h7F;
      dp     <= 1'b1;
      an_out <= 4'hF;
    end else begin
      seg    <= seg_nxt;
      dp     <= dp_nxt;
      an_out <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
// Self-checking bench for seg_display_driver: scoreboard of accepted values,
// checked digit by digit against an arithmetic model of the display.
module tb_seg_display_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [3:0]  anode;
  logic        en;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an_out;
  logic        ovf;

  int tests  = 0;
  int errors = 0;
  int exp_q[$];

  seg_display_driver #(.DIN_W(14), .MAX_VAL(9999)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .anode(anode), .en(en), .blank_lz(blank_lz),
    .dp_mask(dp_mask), .seg(seg), .dp(dp), .an_out(an_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Digit i of val, with leading-zero blanking expressed as val < 10^i.
  function automatic logic [6:0] exp_seg(int val, int i, bit blank);
    int p;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (val > 9999) return 7'b0111111;
    if (blank && i > 0 && val < p) return 7'h7F;
    return seg_of((val / p) % 10);
  endfunction

  task automatic send(int val, bit push);
    din       = 14'(val);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    if (push) exp_q.push_back(val);
  endtask

  task automatic wait_commit(string name, int exp_cycles);
    int cnt;
    cnt = 0;
    while (!din_ready && cnt < 100) begin
      cnt++;
      tick();
    end
    tests++;
    if (cnt !== exp_cycles) begin
      errors++;
      $display("[TB] FAIL %s busy cycles: got %0d expected %0d", name, cnt, exp_cycles);
    end
  endtask

  task automatic check_display(string name);
    int val;
    logic [3:0] oh;
    if (exp_q.size() == 0) begin
      tests++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty", name);
      return;
    end
    val = exp_q.pop_front();
    for (int i = 3; i >= 0; i--) begin
      oh    = 4'b0001 << i;
      anode = oh;
      tick();
      tests++;
      if (seg !== exp_seg(val, i, blank_lz) || an_out !== ~oh || dp !== ~dp_mask[i]) begin
        errors++;
        $display("[TB] FAIL %s digit%0d val=%0d: seg=%b an=%b dp=%b expected seg=%b an=%b dp=%b",
                 name, i, val, seg, an_out, dp, exp_seg(val, i, blank_lz), ~oh, ~dp_mask[i]);
      end
    end
    tests++;
    if (ovf !== (val > 9999)) begin
      errors++;
      $display("[TB] FAIL %s ovf: got %b expected %b", name, ovf, (val > 9999));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; anode = 4'b1000; en = 1'b1; blank_lz = 1'b0;
    dp_mask = 4'b0000; din = '0; din_valid = 1'b0;
    tick(); tick();
    tests++;
    if (seg !== 7'h7F || an_out !== 4'hF || dp !== 1'b1 || din_ready !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: seg=%b an=%b dp=%b rdy=%b ovf=%b expected 1111111 1111 1 0 0",
               seg, an_out, dp, din_ready, ovf);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (seg !== 7'b1000000 || an_out !== 4'b0111 || din_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_idle: seg=%b an=%b rdy=%b expected 1000000 0111 1",
               seg, an_out, din_ready);
    end
  endtask

  task automatic test_conversion();
    en = 1'b1; blank_lz = 1'b0; dp_mask = 4'b0100;
    send(1234, 1'b1);
    wait_commit("conv_1234", 15);
    check_display("conv_1234");
  endtask

  task automatic test_commit_sync();
    bit held;
    en = 1'b0; dp_mask = 4'b0000;
    send(42, 1'b1);
    held = 1'b1;
    din = 14'd777;
    din_valid = 1'b1;
    for (int c = 0; c < 55; c++) begin
      tick();
      if (din_ready !== 1'b0) held = 1'b0;
    end
    din_valid = 1'b0;
    tests++;
    if (!held) begin
      errors++;
      $display("[TB] FAIL commit_hold_ready: got ready high expected low while en=0");
    end
    tests++;
    if (seg !== exp_seg(1234, 0, 1'b0)) begin
      errors++;
      $display("[TB] FAIL commit_hold_display: seg=%b expected %b", seg, exp_seg(1234, 0, 1'b0));
    end
    en = 1'b1;
    tick();
    tests++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL commit_release_ready: got %b expected 1", din_ready);
    end
    check_display("commit_42");
  endtask

  task automatic test_leading_zeros();
    en = 1'b1; blank_lz = 1'b1; dp_mask = 4'b1000;
    send(7, 1'b1);
    wait_commit("lz_7", 15);
    check_display("lz_7");
    send(1000, 1'b1);
    wait_commit("lz_1000", 15);
    check_display("lz_1000");
  endtask

  task automatic test_overflow();
    en = 1'b1; blank_lz = 1'b1; dp_mask = 4'b1010;
    send(9999, 1'b1);
    wait_commit("max_9999", 15);
    check_display("max_9999");
    send(10000, 1'b1);
    wait_commit("ovf_10000", 1);
    check_display("ovf_10000");
    blank_lz = 1'b0;
    send(305, 1'b1);
    wait_commit("after_ovf", 15);
    check_display("after_ovf");
  endtask

  task automatic test_illegal_select();
    logic [3:0] pats [2];
    pats[0] = 4'b0000;
    pats[1] = 4'b1100;
    for (int p = 0; p < 2; p++) begin
      anode = pats[p];
      tick();
      tests++;
      if (seg !== 7'h7F || an_out !== 4'hF || dp !== 1'b1) begin
        errors++;
        $display("[TB] FAIL illegal_anode %b: seg=%b an=%b dp=%b expected 1111111 1111 1",
                 pats[p], seg, an_out, dp);
      end
    end
  endtask

  task automatic test_midop_reset();
    en = 1'b1; blank_lz = 1'b0; dp_mask = 4'b0001;
    send(5678, 1'b0);
    for (int c = 0; c < 5; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tests++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midop_ready: got %b expected 1", din_ready);
    end
    for (int c = 0; c < 20; c++) tick();
    exp_q.push_back(0);
    check_display("midop_reset");
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_commit_sync();
    test_leading_zeros();
    test_overflow();
    test_illegal_select();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
